// File: rtl/elevator_pkg.sv
// Shared definitions for the elevator request table: car status codes,
// default floor count and a floor mask helper.
package elevator_pkg;

    localparam int DEF_NUM_FLOORS = 8;
    localparam int MAX_FLOORS     = 16;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_MOVE_UP   = 4'd1,
        ST_MOVE_DOWN = 4'd2,
        ST_DOOR_OPEN = 4'd7
    } status_e;

    // Ones in bit positions 0..n-1.
    function automatic logic [MAX_FLOORS-1:0] low_mask(input int n);
        logic [MAX_FLOORS-1:0] m;
        m = '0;
        for (int i = 0; i < MAX_FLOORS; i++)
            if (i < n) m[i] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/btn_conditioner.sv
// One push-button: optional debounce filter (REQ_DEBOUNCE_EN) followed by a
// rising-edge detector producing a single-cycle press pulse.
module btn_conditioner #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press
);

    logic lvl;
    logic prev;

`ifdef REQ_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            lvl <= 1'b0;
        end else if (btn != lvl) begin
            if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                lvl <= btn;
                cnt <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end else begin
            cnt <= '0;
        end
    end
`else
    assign lvl = btn;
`endif

    // History tracks the level even in reset, so a button held through
    // reset is seen as already high and never yields a press.
    always_ff @(posedge clk) begin
        prev <= lvl;
    end

    assign press = lvl & ~prev & ~rst;

endmodule

// File: rtl/elevator_request_table.sv
// Latched hall/car request table with service clear and direction hints.
// Optional build macro: REQ_DEBOUNCE_EN (debounce filter on each button).
module elevator_request_table
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS      = DEF_NUM_FLOORS,
    parameter int FLOOR_W         = $clog2(NUM_FLOORS),
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_FLOORS-1:0] sw,
    input  logic                  btnu,
    input  logic                  btnd,
    input  logic                  btnc,
    input  logic [FLOOR_W-1:0]    floor,
    input  logic [3:0]            status,
    input  logic                  nextup,
    input  logic                  nextdown,
    output logic [NUM_FLOORS-1:0] up,
    output logic [NUM_FLOORS-1:0] down,
    output logic [NUM_FLOORS-1:0] elevator_btn,
    output logic                  req_above,
    output logic                  req_below,
    output logic                  req_here,
    output logic                  any_req
);

    // No up call from the top floor, no down call from the ground floor.
    localparam logic [NUM_FLOORS-1:0] UP_MASK = NUM_FLOORS'(low_mask(NUM_FLOORS - 1));
    localparam logic [NUM_FLOORS-1:0] DN_MASK = NUM_FLOORS'(low_mask(NUM_FLOORS)) & ~NUM_FLOORS'(1);

    logic [2:0] btn_raw;
    logic [2:0] press;

    assign btn_raw = {btnc, btnd, btnu};

    for (genvar b = 0; b < 3; b++) begin : g_btn
        btn_conditioner #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_btn (
            .clk  (clk),
            .rst  (rst),
            .btn  (btn_raw[b]),
            .press(press[b])
        );
    end

    logic [NUM_FLOORS-1:0] here_oh, above_m, below_m, all_req;
    logic [NUM_FLOORS-1:0] clr_up, clr_dn, clr_car;
    logic                  door;

    // An out-of-range floor gives an empty here/above set and a full below
    // set, which also disables every clear.
    always_comb begin
        here_oh = '0;
        above_m = '0;
        below_m = '0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            here_oh[i] = (int'(floor) == i);
            above_m[i] = (i > int'(floor));
            below_m[i] = (i < int'(floor));
        end
    end

    always_comb begin
        door    = (status == ST_DOOR_OPEN);
        clr_car = door ? here_oh : '0;
        clr_up  = (door && !(nextdown && !nextup)) ? here_oh : '0;
        clr_dn  = (door && !(nextup && !nextdown)) ? here_oh : '0;
    end

    // Clear is applied after the set so a press at an open door is served.
    always_ff @(posedge clk) begin
        if (rst) begin
            up           <= '0;
            down         <= '0;
            elevator_btn <= '0;
        end else begin
            up           <= (up | (press[0] ? (sw & UP_MASK) : '0)) & ~clr_up;
            down         <= (down | (press[1] ? (sw & DN_MASK) : '0)) & ~clr_dn;
            elevator_btn <= (elevator_btn | (press[2] ? sw : '0)) & ~clr_car;
        end
    end

    assign all_req   = up | down | elevator_btn;
    assign any_req   = |all_req;
    assign req_here  = |(all_req & here_oh);
    assign req_above = |(all_req & above_m);
    assign req_below = |(all_req & below_m);

endmodule

// File: tb/tb_elevator_request_table.sv
// Self-checking bench for elevator_request_table: directed steps plus
// randomized traffic checked against a per-floor reference model.
module tb_elevator_request_table;

    localparam int N  = 8;
    localparam int FW = 3;

    logic          clk = 1'b0;
    logic          rst, btnu, btnd, btnc, nextup, nextdown;
    logic [N-1:0]  sw;
    logic [FW-1:0] floor;
    logic [3:0]    status;
    logic [N-1:0]  up, down, elevator_btn;
    logic          req_above, req_below, req_here, any_req;

    int nchk  = 0;
    int npass = 0;

    bit mu[N], md[N], mc[N];
    bit pu, pd, pc;

    elevator_request_table #(
        .NUM_FLOORS(N),
        .FLOOR_W(FW),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk(clk), .rst(rst), .sw(sw), .btnu(btnu), .btnd(btnd), .btnc(btnc),
        .floor(floor), .status(status), .nextup(nextup), .nextdown(nextdown),
        .up(up), .down(down), .elevator_btn(elevator_btn),
        .req_above(req_above), .req_below(req_below), .req_here(req_here),
        .any_req(any_req)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        assert (got === exp) npass++;
        else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [N-1:0] pack(input bit v[N]);
        logic [N-1:0] r;
        for (int f = 0; f < N; f++) r[f] = v[f];
        return r;
    endfunction

    // Reference behaviour of one clock edge, evaluated with the inputs
    // that the edge is about to sample.
    task automatic model_edge();
        bit eu, ed, ec, door, hit, cu, cd;
        if (rst) begin
            for (int f = 0; f < N; f++) begin
                mu[f] = 0; md[f] = 0; mc[f] = 0;
            end
        end else begin
            eu   = btnu && !pu;
            ed   = btnd && !pd;
            ec   = btnc && !pc;
            door = (status == 4'd7);
            for (int f = 0; f < N; f++) begin
                hit = door && (int'(floor) == f);
                cu  = hit && (nextup || !nextdown);
                cd  = hit && (nextdown || !nextup);
                if (eu && sw[f] && f != N - 1) mu[f] = 1;
                if (ed && sw[f] && f != 0)     md[f] = 1;
                if (ec && sw[f])               mc[f] = 1;
                if (cu)  mu[f] = 0;
                if (cd)  md[f] = 0;
                if (hit) mc[f] = 0;
            end
        end
        pu = btnu; pd = btnd; pc = btnc;
    endtask

    task automatic check_all(input string tag);
        bit a, b, h, any, r;
        a = 0; b = 0; h = 0; any = 0;
        for (int f = 0; f < N; f++) begin
            r = mu[f] || md[f] || mc[f];
            any = any || r;
            if (r && f > int'(floor))  a = 1;
            if (r && f < int'(floor))  b = 1;
            if (r && f == int'(floor)) h = 1;
        end
        chk({tag, ".up"},   32'(up),           32'(pack(mu)));
        chk({tag, ".down"}, 32'(down),         32'(pack(md)));
        chk({tag, ".car"},  32'(elevator_btn), 32'(pack(mc)));
        chk({tag, ".above"}, 32'(req_above), 32'(a));
        chk({tag, ".below"}, 32'(req_below), 32'(b));
        chk({tag, ".here"},  32'(req_here),  32'(h));
        chk({tag, ".any"},   32'(any_req),   32'(any));
    endtask

    task automatic step(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1; btnu = 0; btnd = 0; btnc = 0; nextup = 0; nextdown = 0;
        sw = '0; floor = '0; status = 4'd0;
        #2;
`ifdef REQ_DEBOUNCE_EN
        tick(); rst = 0;
        chk("db.reset", 32'(elevator_btn), 32'h0);
        sw = 8'h20; btnc = 1;
        repeat (3) tick();
        btnc = 0;
        repeat (6) tick();
        chk("db.glitch", 32'(elevator_btn), 32'h0);
        btnc = 1;
        repeat (4) tick();
        chk("db.early", 32'(elevator_btn), 32'h0);
        tick();
        chk("db.latch", 32'(elevator_btn), 32'h20);
        tick(); btnc = 0;
        repeat (8) tick();
        chk("db.hold", 32'(elevator_btn), 32'h20);
`else
        step("reset");
        chk("reset.any", 32'(any_req), 32'h0);
        rst = 0;
        step("idle");

        // basic latch
        sw = 8'h98; btnc = 1;
        step("latch");
        chk("latch.car_c", 32'(elevator_btn), 32'h98);
        chk("latch.any_c", 32'(any_req), 32'h1);
        btnc = 0; step("latch.rel");

        // top/bottom masking
        sw = 8'h81; btnu = 1; step("mask.u");
        btnu = 0; step("mask.u0");
        btnd = 1; step("mask.d");
        btnd = 0; step("mask.d0");
        chk("mask.up_c", 32'(up), 32'h01);
        chk("mask.dn_c", 32'(down), 32'h80);

        // directional clear
        rst = 1; step("dc.rst"); rst = 0;
        sw = 8'h0C; btnu = 1; btnd = 1; step("dc.set");
        btnu = 0; btnd = 0; step("dc.rel");
        floor = 3; status = 4'd7; nextup = 1; step("dc.upclr");
        chk("dc.up_c", 32'(up), 32'h04);
        chk("dc.dn_c", 32'(down), 32'h0C);
        nextup = 0; nextdown = 1; step("dc.dnclr");
        chk("dc.dn2_c", 32'(down), 32'h04);
        status = 4'd0; nextdown = 0;

        // hints
        rst = 1; step("h.rst"); rst = 0;
        sw = 8'h90; btnc = 1; step("h.set");
        btnc = 0; step("h.f3");
        chk("h.f3.above_c", 32'(req_above), 32'h1);
        chk("h.f3.below_c", 32'(req_below), 32'h0);
        floor = 5; #1; check_all("h.f5");
        chk("h.f5.here_c", 32'(req_here), 32'h0);
        floor = 4; #1; check_all("h.f4");
        chk("h.f4.here_c", 32'(req_here), 32'h1);

        // set/clear collision, then reset with a held button
        status = 4'd7; step("col.open");
        sw = 8'h10; btnc = 1; step("col.press");
        chk("col.car_c", 32'(elevator_btn), 32'h80);
        btnc = 0; status = 4'd0;
        sw = 8'h0F; btnu = 1; step("rh.set");
        rst = 1; step("rh.rst");
        chk("rh.up_c", 32'(up), 32'h0);
        rst = 0; step("rh.held1"); step("rh.held2");
        chk("rh.up2_c", 32'(up), 32'h0);
        btnu = 0; step("rh.rel");

        // randomized traffic
        for (int k = 0; k < 300; k++) begin
            rst  = ($urandom_range(39) == 0);
            btnu = $urandom_range(2) == 0;
            btnd = $urandom_range(2) == 0;
            btnc = $urandom_range(2) == 0;
            sw   = N'($urandom);
            floor = FW'($urandom);
            case ($urandom_range(5))
                0: status = 4'd0;
                1: status = 4'd1;
                2: status = 4'd2;
                3: status = 4'd3;
                default: status = 4'd7;
            endcase
            nextup   = $urandom_range(1) == 1;
            nextdown = $urandom_range(1) == 1;
            step("rand");
        end
`endif
        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
